// File: rtl/pulse_stretcher.sv
// Stretches each accepted rising edge of trig_in into a LEN*DIV-cycle level, then a one-cycle done.
// Optional build macro PULSE_STRETCHER_RETRIGGER_EN lets a rise during HOLD restart the stretch.
module pulse_stretcher #(
  parameter int DIV   = 256,
  parameter int LEN   = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  output logic level_out,
  output logic done,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LEN_LOAD = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_trigQ;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic             w_rise;
  logic             w_tick;
  logic             w_reload;

  assign w_rise = trig_in & ~r_trigQ;
  assign w_tick = (r_state == HOLD) && (r_pcnt == DIV_LAST);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign w_reload = w_rise && ((r_state == IDLE) || (r_state == HOLD));
`else
  assign w_reload = w_rise && (r_state == IDLE);
`endif

  // A reload in HOLD beats the final tick, so DONE is only reached when no rise restarts the stretch.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_rise) w_nextState = HOLD;
      HOLD: if (w_tick && (r_lcnt == ONE) && !w_reload) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_trigQ   <= 1'b0;
      r_pcnt    <= '0;
      r_lcnt    <= '0;
      level_out <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_trigQ <= trig_in;
      if (w_reload) begin
        r_pcnt <= '0;
        r_lcnt <= LEN_LOAD;
      end else if (r_state == HOLD) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + ONE;
        if (w_tick && (r_lcnt != ONE)) r_lcnt <= r_lcnt - ONE;
      end
      level_out <= (w_nextState == HOLD);
      done      <= (w_nextState == DONE);
      busy      <= (w_nextState == HOLD) || (w_nextState == DONE);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: three instances (4x3, 1x1, defaults) share one clock.
// Expected stretch lengths are queued per instance and popped when that instance pulses done.
module tb_pulse_stretcher;

  logic       clk;
  logic [2:0] trig;
  logic [2:0] rstN;
  wire  [2:0] lvl;
  wire  [2:0] dn;
  wire  [2:0] bs;

  int checkCount = 0;
  int failCount  = 0;
  int expQ[3][$];
  int runLen[3];
  logic prevDn[3];

  pulse_stretcher #(.DIV(4), .LEN(3), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rstN[0]), .trig_in(trig[0]),
    .level_out(lvl[0]), .done(dn[0]), .busy(bs[0])
  );

  pulse_stretcher #(.DIV(1), .LEN(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rstN[1]), .trig_in(trig[1]),
    .level_out(lvl[1]), .done(dn[1]), .busy(bs[1])
  );

  pulse_stretcher u_c (
    .clk(clk), .rst_n(rstN[2]), .trig_in(trig[2]),
    .level_out(lvl[2]), .done(dn[2]), .busy(bs[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hold trig high across the given number of rising edges, then drop it just after the last one.
  task automatic applyStimulus(input int idx, input int cycles);
    trig[idx] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    trig[idx] = 1'b0;
  endtask

  task automatic waitIdle(input int idx, input int budget);
    int n = 0;
    while (((expQ[idx].size() != 0) || (bs[idx] == 1'b1)) && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("idleWithinBudget%0d", idx), int'(n < budget), 1);
  endtask

  // Measure each level run mid-cycle and settle it against the scoreboard when done appears.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstN[i]) begin
        runLen[i] = 0;
        prevDn[i] = 1'b0;
      end else begin
        if (dn[i] && prevDn[i]) checkOutput($sformatf("doneWidth%0d", i), 2, 1);
        if (dn[i]) begin
          checkOutput($sformatf("levelLowWithDone%0d", i), int'(lvl[i]), 0);
          if (expQ[i].size() == 0) checkOutput($sformatf("unexpectedDone%0d", i), 0, expQ[i].size() + 1);
          else checkOutput($sformatf("stretchLen%0d", i), runLen[i], expQ[i].pop_front());
          runLen[i] = 0;
        end else if (lvl[i]) begin
          runLen[i]++;
        end else if (runLen[i] != 0) begin
          checkOutput($sformatf("levelEndedWithoutDone%0d", i), int'(dn[i]), 1);
          runLen[i] = 0;
        end
        prevDn[i] = dn[i];
      end
    end
  end

  always @(negedge clk) begin
    if (u_a.r_pcnt > 16'd3) checkOutput("pcntRangeA", int'(u_a.r_pcnt), 3);
    if (u_b.r_pcnt > 16'd0) checkOutput("pcntRangeB", int'(u_b.r_pcnt), 0);
    if (u_c.r_pcnt > 16'd255) checkOutput("pcntRangeC", int'(u_c.r_pcnt), 255);
  end

  initial begin
    int expRetrig;
    trig = '0;
    rstN = '0;
    for (int i = 0; i < 3; i++) begin
      runLen[i] = 0;
      prevDn[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("resetLevel%0d", i), int'(lvl[i]), 0);
      checkOutput($sformatf("resetDone%0d", i), int'(dn[i]), 0);
      checkOutput($sformatf("resetBusy%0d", i), int'(bs[i]), 0);
    end
    rstN = '1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single pulse, DIV=4 LEN=3");
    expQ[0].push_back(12);
    applyStimulus(0, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_levelMid", int'(lvl[0]), 1);
    checkOutput("a_busyMid", int'(bs[0]), 1);
    waitIdle(0, 40);
    checkOutput("a_levelAfter", int'(lvl[0]), 0);

    $display("[TB] held trigger, DIV=4 LEN=3");
    expQ[0].push_back(12);
    applyStimulus(0, 40);
    waitIdle(0, 20);

    $display("[TB] DIV=1 LEN=1, second pulse lands in DONE");
    expQ[1].push_back(1);
    trig[1] = 1'b1;
    @(posedge clk);
    #1;
    trig[1] = 1'b0;
    checkOutput("b_levelCycle1", int'(lvl[1]), 1);
    @(posedge clk);
    #1;
    trig[1] = 1'b1;
    checkOutput("b_doneCycle2", int'(dn[1]), 1);
    checkOutput("b_levelCycle2", int'(lvl[1]), 0);
    @(posedge clk);
    #1;
    trig[1] = 1'b0;
    checkOutput("b_levelCycle3", int'(lvl[1]), 0);
    checkOutput("b_busyCycle3", int'(bs[1]), 0);
    waitIdle(1, 10);

    $display("[TB] async reset mid-HOLD");
    applyStimulus(0, 1);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("r_levelBeforeReset", int'(lvl[0]), 1);
    rstN[0] = 1'b0;
    #1;
    checkOutput("r_levelAsync", int'(lvl[0]), 0);
    checkOutput("r_busyAsync", int'(bs[0]), 0);
    checkOutput("r_doneAsync", int'(dn[0]), 0);
    @(posedge clk);
    #1;
    rstN[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("r_busyAfterRelease", int'(bs[0]), 0);

    $display("[TB] second rise 8 cycles into HOLD");
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    expRetrig = 20;
`else
    expRetrig = 12;
`endif
    expQ[0].push_back(expRetrig);
    applyStimulus(0, 1);
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(0, 1);
    waitIdle(0, 40);

    $display("[TB] default parameters, DIV=256 LEN=4");
    expQ[2].push_back(1024);
    applyStimulus(2, 1);
    repeat (500) @(posedge clk);
    #1;
    checkOutput("c_levelMid", int'(lvl[2]), 1);
    waitIdle(2, 1200);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
